keypad_time_loader: RTL and testbench
=====================================

# keypad_time_loader

- Front-end writer for the microwave countdown chain.
- Captures one-hot keypad digits microwave-style: each new digit shifts left through seconds-ones, seconds-tens and minutes.
- Validates the entered time and drives the `data`/`loadn` load interface of the counter10/counter6 digit counters.
- Locks out entry while the timer runs; clears entry when the count finishes.

## Interface
Parameters:
- `LOAD_CYCLES`, default 2: number of cycles `loadn` is held low per load (range 1–15).
- `MAX_DIGITS`, default 3: digits accepted before further keys are ignored (range 1–3).

Ports:
- `clk` input 1: single system clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `keypad` input 10: one-hot key lines; bit k = digit k.
- `start` input 1: start request, level, edge-detected internally.
- `clear` input 1: clear request, level, edge-detected internally.
- `counting` input 1: high while the counter chain is decrementing; driven by the timer `enable`.
- `sec_ones` output 4: BCD digit, loaded into the seconds-ones counter10.
- `sec_tens` output 4: BCD digit, loaded into the seconds-tens counter6.
- `mins` output 4: BCD digit, loaded into the minutes counter10.
- `loadn` output 1: active-low load strobe to all digit counters.
- `digits` output 2: number of digits entered so far.
- `err` output 1: one-cycle pulse on a rejected start.
- `locked` output 1: high in LOAD and RUN.

## Operation
States:
- **IDLE**: `digits`=0, all outputs zero.
- **ENTRY**: accepting digits.
- **LOAD**: `loadn` low.
- **RUN**: timer active.

Input capture:
- `keypad`, `start` and `clear` each pass through one register stage (`*_q`), then a previous-value stage (`*_q2`).
- Key press event: `keypad_q` has exactly one bit set and `keypad_q2`==0.
- Multi-bit or non-released patterns produce no event.
- `start` and `clear` events: rising edge of `*_q`.

Digit entry (IDLE/ENTRY):
- On a key event with `digits` < `MAX_DIGITS`:
  - `mins`<=`sec_tens`, `sec_tens`<=`sec_ones`, `sec_ones`<=key index, `digits`+=1.
  - IDLE moves to ENTRY.
- On a key event with `digits`==`MAX_DIGITS`: ignored.

Start:
- Start event in ENTRY with `sec_tens` ≤ 5 → LOAD.
- Start event in ENTRY with `sec_tens` > 5 → `err`=1 for one cycle; stay in ENTRY; digits retained.
- Start event in IDLE: see Configuration.

Clear:
- Clear event in IDLE/ENTRY → IDLE, digits zeroed.
- In LOAD/RUN, clear is ignored; abort is handled by the timer's own `rstn`/`enable`.

LOAD:
- `loadn`=0 for exactly `LOAD_CYCLES` cycles; digit outputs held stable throughout.
- Then → RUN.

RUN:
- Keys, start and clear are ignored.
- Wait for `counting` to rise, then fall.
- On the fall → IDLE, digits zeroed.
- If `counting` never rises within 16 cycles of entering RUN → IDLE (timer not enabled).

Priority when events coincide in one cycle: clear > start > key. A key arriving with start is discarded.

## Timing
- Reset values: `sec_ones`=`sec_tens`=`mins`=0, `digits`=0, `loadn`=1, `err`=0, `locked`=0, state IDLE, all capture registers 0.
- Key latency: key asserted before edge N → captured at N → digit outputs and `digits` updated at edge N+1.
- Start latency: start asserted before edge N → state LOAD and `loadn`=0 from edge N+1 through edge N+`LOAD_CYCLES`; `loadn`=1 again at edge N+1+`LOAD_CYCLES`.
- `err` asserts at edge N+1, deasserts at N+2.
- `locked` rises with `loadn` falling; falls on the edge after `counting` falls.
- `rstn` low mid-LOAD or mid-RUN: `loadn` returns to 1 immediately (asynchronously), everything else to reset values.
- All outputs are registered; no combinational paths from inputs to outputs.

## Configuration
- `QUICK_START_EN` defined:
  - A start event in IDLE loads 00:30: `sec_ones`=0, `sec_tens`=3, `mins`=0, `digits`=2; → LOAD with the same timing as a normal start.
- Undefined:
  - A start event in IDLE is ignored: no `err`, no `loadn`.

## Test plan
- Reset then keys 1,2,3 (each held 3 cycles, released 2) → `mins`=1, `sec_tens`=2, `sec_ones`=3, `digits`=3; a fourth key 9 → unchanged.
- Keys 4 then 7, start pulse → `loadn` low exactly 2 cycles with `sec_tens`=4, `sec_ones`=7, `locked`=1; `counting` 1 for 20 cycles then 0 → IDLE, outputs 0.
- Keys 1,8,0 then start → `err` one-cycle pulse, `loadn` stays 1, digits kept; clear → all zero, `digits`=0.
- `keypad`=10'b0000000011 → no digit; `start` and `clear` on the same cycle in ENTRY → IDLE, no load.
- Keys 5,0, start, `rstn` low during the second `loadn` cycle → `loadn`=1 immediately, all outputs 0, state IDLE.
- Start in IDLE: with `QUICK_START_EN` → `loadn` pulse with 0/3/0; without it → no response.

Source files
------------

// File: rtl/keypad_time_loader.sv
// ============================================================================
// keypad_time_loader
// ----------------------------------------------------------------------------
// Front-end writer for the microwave countdown chain. One-hot keypad digits
// are captured microwave-style (each new digit shifts left through
// seconds-ones -> seconds-tens -> minutes). The entered time is validated and
// then presented on the digit outputs while loadn_o is held low, which loads
// the counter10/counter6 digit counters. Entry is locked out while the timer
// runs, and the entry is cleared once the count finishes.
//
// Optional feature macro: QUICK_START_EN
//   defined   : a start event in IDLE loads 00:30 and starts a load cycle.
//   undefined : a start event in IDLE is ignored.
//
// Parameters:
//   LOAD_CYCLES  cycles loadn_o is held low per load (1..15)
//   MAX_DIGITS   digits accepted before further keys are ignored (1..3)
//
// Ports:
//   clk_i        system clock, rising edge
//   rstn_i       asynchronous active-low reset
//   keypad_i     one-hot key lines, bit k = digit k
//   start_i      start request (level, edge-detected internally)
//   clear_i      clear request (level, edge-detected internally)
//   counting_i   high while the counter chain is decrementing
//   sec_ones_o   BCD seconds-ones digit
//   sec_tens_o   BCD seconds-tens digit
//   mins_o       BCD minutes digit
//   loadn_o      active-low load strobe to all digit counters
//   digits_o     number of digits entered so far
//   err_o        one-cycle pulse on a rejected start
//   locked_o     high while loading or running
// ============================================================================
module keypad_time_loader #(
    parameter int LOAD_CYCLES = 2,
    parameter int MAX_DIGITS  = 3
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [9:0] keypad_i,
    input  logic       start_i,
    input  logic       clear_i,
    input  logic       counting_i,
    output logic [3:0] sec_ones_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] mins_o,
    output logic       loadn_o,
    output logic [1:0] digits_o,
    output logic       err_o,
    output logic       locked_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_e;

    localparam logic [3:0] LoadInit   = 4'(LOAD_CYCLES - 1);
    localparam logic [1:0] DigitLimit = 2'(MAX_DIGITS);
    localparam logic [3:0] RunTimeout = 4'd15;

    // Input capture pipeline
    logic [9:0] keypad_q, keypad_q2;
    logic       start_q, start_q2;
    logic       clear_q, clear_q2;

    // Control state
    state_e     state_q, state_d;
    logic [3:0] loadCnt_q, loadCnt_d;
    logic [3:0] runCnt_q, runCnt_d;
    logic       seenCount_q, seenCount_d;

    // Registered outputs
    logic [3:0] secOnes_q, secOnes_d;
    logic [3:0] secTens_q, secTens_d;
    logic [3:0] mins_q, mins_d;
    logic [1:0] digits_q, digits_d;
    logic       loadn_q, loadn_d;
    logic       err_q, err_d;
    logic       locked_q, locked_d;

    // Decoded events
    logic [9:0] keyMinusOne;
    logic       keyOneHot;
    logic       keyEvent;
    logic       startEvent;
    logic       clearEvent;
    logic [3:0] keyIdx;
    logic       entryState;
    logic       keyAccept;
    logic       tensValid;

    // Every request input goes through a capture stage and then a
    // previous-value stage so edges can be detected on clean, registered
    // copies. Nothing downstream ever looks at the raw inputs except
    // counting_i, which comes from our own timer and is already synchronous.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            keypad_q  <= '0;
            keypad_q2 <= '0;
            start_q   <= 1'b0;
            start_q2  <= 1'b0;
            clear_q   <= 1'b0;
            clear_q2  <= 1'b0;
        end else begin
            keypad_q  <= keypad_i;
            keypad_q2 <= keypad_q;
            start_q   <= start_i;
            start_q2  <= start_q;
            clear_q   <= clear_i;
            clear_q2  <= clear_q;
        end
    end

    // A key press counts only when exactly one line is set and the previous
    // sample was fully released. This rejects chords and keeps a held key
    // from auto-repeating; sliding from one key to another without release
    // is also ignored.
    assign keyMinusOne = keypad_q - 10'd1;
    assign keyOneHot   = (keypad_q != '0) && ((keypad_q & keyMinusOne) == '0);
    assign keyEvent    = keyOneHot && (keypad_q2 == '0);
    assign startEvent  = start_q && !start_q2;
    assign clearEvent  = clear_q && !clear_q2;

    // Convert the one-hot key sample into its digit value. Only meaningful
    // when keyOneHot is true, which is the only time it is consumed.
    always_comb begin
        keyIdx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad_q[i]) begin
                keyIdx = 4'(i);
            end
        end
    end

    // Clear beats start, and start beats key, so a key that lands in the
    // same cycle as either request is simply dropped.
    assign entryState = (state_q == IDLE) || (state_q == ENTRY);
    assign keyAccept  = entryState && keyEvent && !startEvent && !clearEvent
                        && (digits_q < DigitLimit);

    // Seconds-tens feeds a counter6, so anything above 5 cannot be loaded.
    assign tensValid  = (secTens_q <= 4'd5);

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RUN waits for counting_i to rise and then fall; if
    // the timer never starts within the timeout window we assume it was not
    // enabled and fall back to IDLE rather than locking up the keypad.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (clearEvent) begin
                    state_d = IDLE;
                end else if (startEvent) begin
`ifdef QUICK_START_EN
                    state_d = LOAD;
`else
                    state_d = IDLE;
`endif
                end else if (keyAccept) begin
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (clearEvent) begin
                    state_d = IDLE;
                end else if (startEvent && tensValid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (loadCnt_q == 4'd0) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (seenCount_q && !counting_i) begin
                    state_d = IDLE;
                end else if (!seenCount_q && !counting_i
                             && (runCnt_q == RunTimeout)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next-value logic. Strobes are derived from the
    // state we are about to enter so that loadn_o and locked_o change on the
    // same edge as the state itself while still coming straight out of
    // flops. Landing in IDLE always wipes the entered time.
    always_comb begin
        secOnes_d   = secOnes_q;
        secTens_d   = secTens_q;
        mins_d      = mins_q;
        digits_d    = digits_q;
        loadCnt_d   = loadCnt_q;
        runCnt_d    = runCnt_q;
        seenCount_d = seenCount_q;
        loadn_d     = (state_d != LOAD);
        locked_d    = (state_d == LOAD) || (state_d == RUN);
        err_d       = (state_q == ENTRY) && startEvent && !clearEvent
                      && !tensValid;

        if (state_d == IDLE) begin
            secOnes_d = 4'd0;
            secTens_d = 4'd0;
            mins_d    = 4'd0;
            digits_d  = 2'd0;
        end else if ((state_q == IDLE) && (state_d == LOAD)) begin
            // Only reachable with the quick-start feature: preset 00:30.
            secOnes_d = 4'd0;
            secTens_d = 4'd3;
            mins_d    = 4'd0;
            digits_d  = 2'd2;
        end else if (keyAccept) begin
            mins_d    = secTens_q;
            secTens_d = secOnes_q;
            secOnes_d = keyIdx;
            digits_d  = digits_q + 2'd1;
        end

        // Load-length counter: armed on entry to LOAD, counts down to zero.
        if ((state_q != LOAD) && (state_d == LOAD)) begin
            loadCnt_d = LoadInit;
        end else if ((state_q == LOAD) && (loadCnt_q != 4'd0)) begin
            loadCnt_d = loadCnt_q - 4'd1;
        end

        // RUN bookkeeping: remember whether the timer has started, and time
        // out if it never does.
        if ((state_q == LOAD) && (state_d == RUN)) begin
            runCnt_d    = 4'd0;
            seenCount_d = 1'b0;
        end else if (state_q == RUN) begin
            if (counting_i) begin
                seenCount_d = 1'b1;
            end else if (!seenCount_q && (runCnt_q != RunTimeout)) begin
                runCnt_d = runCnt_q + 4'd1;
            end
        end
    end

    // Datapath and output registers. The asynchronous reset drives loadn
    // back high at once so an abort never leaves the counters mid-load.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            secOnes_q   <= 4'd0;
            secTens_q   <= 4'd0;
            mins_q      <= 4'd0;
            digits_q    <= 2'd0;
            loadn_q     <= 1'b1;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            loadCnt_q   <= 4'd0;
            runCnt_q    <= 4'd0;
            seenCount_q <= 1'b0;
        end else begin
            secOnes_q   <= secOnes_d;
            secTens_q   <= secTens_d;
            mins_q      <= mins_d;
            digits_q    <= digits_d;
            loadn_q     <= loadn_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
            loadCnt_q   <= loadCnt_d;
            runCnt_q    <= runCnt_d;
            seenCount_q <= seenCount_d;
        end
    end

    assign sec_ones_o = secOnes_q;
    assign sec_tens_o = secTens_q;
    assign mins_o     = mins_q;
    assign digits_o   = digits_q;
    assign loadn_o    = loadn_q;
    assign err_o      = err_q;
    assign locked_o   = locked_q;

endmodule

// File: tb/tb_keypad_time_loader.sv
// ============================================================================
// tb_keypad_time_loader
// ----------------------------------------------------------------------------
// Self-checking bench for keypad_time_loader (default parameters). Expected
// output snapshots are pushed onto a queue as stimulus is driven and popped
// when the corresponding clock edge has produced the DUT output.
// Honours QUICK_START_EN the same way the design does.
// ============================================================================
module tb_keypad_time_loader;

    typedef struct packed {
        logic [3:0] mins;
        logic [3:0] secTens;
        logic [3:0] secOnes;
        logic [1:0] digits;
        logic       loadn;
        logic       err;
        logic       locked;
    } snap_t;

    localparam int MaxDigits = 3;

    logic       clk;
    logic       rstn;
    logic [9:0] keypad;
    logic       start;
    logic       clear;
    logic       counting;
    logic [3:0] secOnes;
    logic [3:0] secTens;
    logic [3:0] mins;
    logic       loadn;
    logic [1:0] digits;
    logic       err;
    logic       locked;

    int checks   = 0;
    int failures = 0;

    // Reference model of the entered time
    logic [3:0] mMins, mTens, mOnes;
    logic [1:0] mDigits;

    snap_t expQ[$];
    snap_t expS;
    snap_t actS;

    keypad_time_loader dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .keypad_i   (keypad),
        .start_i    (start),
        .clear_i    (clear),
        .counting_i (counting),
        .sec_ones_o (secOnes),
        .sec_tens_o (secTens),
        .mins_o     (mins),
        .loadn_o    (loadn),
        .digits_o   (digits),
        .err_o      (err),
        .locked_o   (locked)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    function automatic snap_t modelSnap(input logic ld, input logic er,
                                        input logic lk);
        snap_t s;
        s.mins    = mMins;
        s.secTens = mTens;
        s.secOnes = mOnes;
        s.digits  = mDigits;
        s.loadn   = ld;
        s.err     = er;
        s.locked  = lk;
        return s;
    endfunction

    function automatic snap_t dutSnap();
        return {mins, secTens, secOnes, digits, loadn, err, locked};
    endfunction

    // Advance n rising edges and settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic modelClear();
        mMins   = 4'd0;
        mTens   = 4'd0;
        mOnes   = 4'd0;
        mDigits = 2'd0;
    endtask

    // Press digit k: held 3 cycles, released 2
    task automatic applyStimulus(input int k);
        keypad = 10'd1 << k;
        tick(3);
        keypad = 10'd0;
        tick(2);
        if (mDigits < 2'(MaxDigits)) begin
            mMins   = mTens;
            mTens   = mOnes;
            mOnes   = 4'(k);
            mDigits = mDigits + 2'd1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(2);
        modelClear();
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL reset_held actual=%h required=%h", actS, expS);
        end
        #3 rstn = 1'b1;
        tick(2);
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL reset_released actual=%h required=%h", actS, expS);
        end
    endtask

    task automatic test_entry();
        int keys[4] = '{1, 2, 3, 9};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(keys[i]);
            expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
            expS = expQ.pop_front();
            actS = dutSnap();
            checks++;
            if (actS !== expS) begin
                failures++;
                $display("[TB] FAIL entry_key%0d actual=%h required=%h", keys[i], actS, expS);
            end
        end
        // Explicit view of the full-entry result 1:23
        checks++;
        if ({mins, secTens, secOnes, digits} !== {4'd1, 4'd2, 4'd3, 2'd3}) begin
            failures++;
            $display("[TB] FAIL entry_123 actual=%h required=%h",
                     {mins, secTens, secOnes, digits}, {4'd1, 4'd2, 4'd3, 2'd3});
        end
        clear = 1'b1;
        tick(2);
        clear = 1'b0;
        modelClear();
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL entry_clear actual=%h required=%h", actS, expS);
        end
    endtask

    task automatic test_load_run();
        int lowCount = 0;
        applyStimulus(4);
        applyStimulus(7);
        start = 1'b1;
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));  // edge N: captured only
        expQ.push_back(modelSnap(1'b0, 1'b0, 1'b1));  // N+1
        expQ.push_back(modelSnap(1'b0, 1'b0, 1'b1));  // N+2
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b1));  // N+3: RUN
        for (int c = 0; c < 4; c++) begin
            tick(1);
            if (c == 1) start = 1'b0;
            if (loadn === 1'b0) lowCount++;
            expS = expQ.pop_front();
            actS = dutSnap();
            checks++;
            if (actS !== expS) begin
                failures++;
                $display("[TB] FAIL load_cycle%0d actual=%h required=%h", c, actS, expS);
            end
        end
        checks++;
        if (lowCount !== 2) begin
            failures++;
            $display("[TB] FAIL load_low_count actual=%0d required=2", lowCount);
        end
        // Timer runs; keys, start and clear must all be ignored
        counting = 1'b1;
        keypad = 10'd1 << 5;
        clear  = 1'b1;
        tick(3);
        keypad = 10'd0;
        clear  = 1'b0;
        start  = 1'b1;
        tick(3);
        start  = 1'b0;
        tick(10);
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b1));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL run_locked actual=%h required=%h", actS, expS);
        end
        tick(4);
        counting = 1'b0;
        #1;
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b1));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL run_before_fall_edge actual=%h required=%h", actS, expS);
        end
        tick(1);
        modelClear();
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL run_done_idle actual=%h required=%h", actS, expS);
        end
    endtask

    task automatic test_reject();
        int tens[2] = '{8, 6};
        for (int t = 0; t < 2; t++) begin
            if (t == 0) applyStimulus(1);
            applyStimulus(tens[t]);
            applyStimulus(0);
            start = 1'b1;
            expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));  // N
            expQ.push_back(modelSnap(1'b1, 1'b1, 1'b0));  // N+1 err
            expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));  // N+2
            expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));  // N+3
            for (int c = 0; c < 4; c++) begin
                tick(1);
                if (c == 1) start = 1'b0;
                expS = expQ.pop_front();
                actS = dutSnap();
                checks++;
                if (actS !== expS) begin
                    failures++;
                    $display("[TB] FAIL reject_tens%0d_cycle%0d actual=%h required=%h",
                             tens[t], c, actS, expS);
                end
            end
            clear = 1'b1;
            tick(2);
            clear = 1'b0;
            modelClear();
            expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
            expS = expQ.pop_front();
            actS = dutSnap();
            checks++;
            if (actS !== expS) begin
                failures++;
                $display("[TB] FAIL reject_clear%0d actual=%h required=%h", tens[t], actS, expS);
            end
        end
    endtask

    task automatic test_multibit_and_priority();
        keypad = 10'b0000000011;
        tick(3);
        keypad = 10'd0;
        tick(2);
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL multibit_ignored actual=%h required=%h", actS, expS);
        end
        applyStimulus(2);
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL single_key2 actual=%h required=%h", actS, expS);
        end
        start = 1'b1;
        clear = 1'b1;
        tick(1);
        modelClear();
        for (int c = 0; c < 3; c++) begin
            tick(1);
            start = 1'b0;
            clear = 1'b0;
            expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
            expS = expQ.pop_front();
            actS = dutSnap();
            checks++;
            if (actS !== expS) begin
                failures++;
                $display("[TB] FAIL clear_over_start%0d actual=%h required=%h", c, actS, expS);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        applyStimulus(5);
        applyStimulus(0);
        start = 1'b1;
        tick(1);
        expQ.push_back(modelSnap(1'b0, 1'b0, 1'b1));
        expQ.push_back(modelSnap(1'b0, 1'b0, 1'b1));
        for (int c = 0; c < 2; c++) begin
            tick(1);
            start = 1'b0;
            expS = expQ.pop_front();
            actS = dutSnap();
            checks++;
            if (actS !== expS) begin
                failures++;
                $display("[TB] FAIL abort_load%0d actual=%h required=%h", c, actS, expS);
            end
        end
        #2 rstn = 1'b0;
        #1;
        modelClear();
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL abort_async actual=%h required=%h", actS, expS);
        end
        #2 rstn = 1'b1;
        tick(3);
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
        expS = expQ.pop_front();
        actS = dutSnap();
        checks++;
        if (actS !== expS) begin
            failures++;
            $display("[TB] FAIL abort_after actual=%h required=%h", actS, expS);
        end
    endtask

    task automatic test_idle_start();
        start = 1'b1;
`ifdef QUICK_START_EN
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
        mTens   = 4'd3;
        mDigits = 2'd2;
        expQ.push_back(modelSnap(1'b0, 1'b0, 1'b1));
        expQ.push_back(modelSnap(1'b0, 1'b0, 1'b1));
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b1));
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b1));  // 8 cycles into RUN
        modelClear();
        expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));  // timed out
        for (int c = 0; c < 6; c++) begin
            if (c < 4) tick(1);
            else if (c == 4) tick(8);
            else tick(12);
            if (c == 1) start = 1'b0;
            expS = expQ.pop_front();
            actS = dutSnap();
            checks++;
            if (actS !== expS) begin
                failures++;
                $display("[TB] FAIL quick_start%0d actual=%h required=%h", c, actS, expS);
            end
        end
`else
        for (int c = 0; c < 4; c++) begin
            expQ.push_back(modelSnap(1'b1, 1'b0, 1'b0));
            tick(1);
            if (c == 1) start = 1'b0;
            expS = expQ.pop_front();
            actS = dutSnap();
            checks++;
            if (actS !== expS) begin
                failures++;
                $display("[TB] FAIL idle_start%0d actual=%h required=%h", c, actS, expS);
            end
        end
`endif
    endtask

    initial begin
        rstn     = 1'b0;
        keypad   = 10'd0;
        start    = 1'b0;
        clear    = 1'b0;
        counting = 1'b0;
        modelClear();
        test_reset();
        test_entry();
        test_load_run();
        test_reject();
        test_multibit_and_priority();
        test_reset_mid_load();
        test_idle_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
